// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: stores received bytes with their parity/framing flags,
// serves bus reads, and reports occupancy, sticky overrun and a fill-level interrupt.
module uart_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_en_i,
    input  logic              rx_done_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_perr_i,
    input  logic              rx_ferr_i,
    input  logic              rd_en_i,
    input  logic              flush_i,
    input  logic              clr_ovr_i,
    input  logic [ADDR_W:0]   thresh_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_perr_o,
    output logic              rd_ferr_o,
    output logic              rd_valid_o,
    output logic [ADDR_W:0]   count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overrun_o,
    output logic              level_irq_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef struct packed {
        logic              ferr;
        logic              perr;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

    rx_entry_t         mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic              push_req_c;
    logic              push_ok_c;
    logic              drop_c;
    logic              pop_c;

    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    always_comb begin
        push_req_c = rx_done_i & rx_en_i & ~flush_i;
        pop_c      = rd_en_i & ~empty_o & ~flush_i;
        push_ok_c  = push_req_c & (~full_o | pop_c);
        drop_c     = push_req_c & full_o & ~pop_c;
        count_nxt  = count_o;
        if (push_ok_c && !pop_c) begin
            count_nxt = count_o + CNT_W'(1);
        end else if (pop_c && !push_ok_c) begin
            count_nxt = count_o - CNT_W'(1);
        end
    end

    // Storage has no reset; only entries written since the last reset are ever read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok_c) begin
            mem[wr_ptr] <= '{ferr: rx_ferr_i, perr: rx_perr_i, data: rx_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_o     <= '0;
            empty_o     <= 1'b1;
            full_o      <= 1'b0;
            rd_data_o   <= '0;
            rd_perr_o   <= 1'b0;
            rd_ferr_o   <= 1'b0;
            rd_valid_o  <= 1'b0;
            overrun_o   <= 1'b0;
            level_irq_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_o     <= '0;
            empty_o     <= 1'b1;
            full_o      <= 1'b0;
            rd_valid_o  <= 1'b0;
            overrun_o   <= 1'b0;
            level_irq_o <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_c) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                rd_data_o <= mem[rd_ptr].data;
                rd_perr_o <= mem[rd_ptr].perr;
                rd_ferr_o <= mem[rd_ptr].ferr;
            end
            rd_valid_o  <= pop_c;
            count_o     <= count_nxt;
            empty_o     <= (count_nxt == '0);
            full_o      <= (count_nxt == CNT_W'(DEPTH));
            level_irq_o <= (thresh_i != '0) && (count_nxt >= thresh_i);
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop_c) begin
                overrun_o <= 1'b1;
            end else if (clr_ovr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer for the UART: the write side accepts bytes from the RX shift/deserializer, and the read side serves CPU/bus reads. It is the counterpart of the transmit FIFO. Each entry stores the received byte plus its parity- and framing-error flags. It also provides occupancy, full/empty, a sticky overrun flag, and a programmable fill-level interrupt.

Parameters:
DATA_W, 8, received character width
DEPTH, 16, number of entries (power of 2)
ADDR_W, 4, log2(DEPTH); pointer width (count is ADDR_W+1 bits)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
rx_en_i  in  1  receiver enable; writes are ignored when 0
rx_done_i  in  1  one-cycle pulse: byte complete from RX deserializer
rx_data_i  in  DATA_W  received byte, valid with rx_done_i
rx_perr_i  in  1  parity error for this byte
rx_ferr_i  in  1  framing (stop-bit) error for this byte
rd_en_i  in  1  bus read strobe, one cycle per pop
flush_i  in  1  clear FIFO contents and flags
clr_ovr_i  in  1  clear sticky overrun
thresh_i  in  ADDR_W+1  interrupt fill threshold (0 = interrupt disabled)
rd_data_o  out  DATA_W  popped byte
rd_perr_o  out  1  parity flag of popped byte
rd_ferr_o  out  1  framing flag of popped byte
rd_valid_o  out  1  one-cycle pulse: rd_* outputs updated
count_o  out  ADDR_W+1  current occupancy, 0..DEPTH
empty_o  out  1  count_o == 0
full_o  out  1  count_o == DEPTH
overrun_o  out  1  sticky: byte dropped because FIFO was full
level_irq_o  out  1  registered: thresh_i != 0 and count_o >= thresh_i

Behaviour:
- Reset: one clock; rst_i is synchronous and active-high.
  - Reset state: wr_ptr=0, rd_ptr=0, count=0, rd_data_o=0, rd_perr_o=0, rd_ferr_o=0, rd_valid_o=0, overrun_o=0, level_irq_o=0.
  - Resulting flags: empty_o=1, full_o=0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all entries on that edge.
- Write (push) = rx_done_i & rx_en_i & !flush_i.
  - If not full, or full with a pop in the same cycle: store {ferr, perr, data} at wr_ptr, and wr_ptr wraps DEPTH-1 -> 0.
  - If full and no pop: the byte is dropped, the pointers are unchanged, and overrun_o is set on the next edge.
- Read (pop) = rd_en_i & !empty_o & !flush_i.
  - The head entry is registered onto rd_* and rd_valid_o=1 on the next edge; latency is 1 cycle.
  - rd_ptr wraps DEPTH-1 -> 0.
  - rd_en_i while empty: no pop, rd_valid_o=0, and rd_data_o holds its previous value (no underflow flag).
  - rd_data_o holds its value until the next pop.
- Simultaneous push and pop: both take effect and count is unchanged.
  - If empty at that moment: the pop is ignored, the push is accepted, and count becomes 1.
- count update: +1 on push only, -1 on pop only. empty_o and full_o are decoded from the registered count.
- flush_i (highest priority after reset):
  - pointers and count go to 0, overrun_o is cleared, rd_valid_o=0.
  - A push or pop in the same cycle is discarded.
  - rd_data_o holds its value.
- overrun_o clearing: set by a dropped byte, cleared by clr_ovr_i or flush_i. Set wins if a drop coincides with clr_ovr_i.
- level_irq_o: registered each cycle from the next-state count, so it aligns with count_o.
- The error flags travel with their byte. They are never merged into overrun_o.

Test Plan:
- Reset, then 3 pushes (0x10, 0x20, 0x30, no errors) -> count_o=3, empty_o=0; 3 rd_en_i pulses give rd_data_o 0x10, 0x20, 0x30 each 1 cycle after rd_en_i with rd_valid_o pulsing; final empty_o=1.
- Push 16 bytes 0x00..0x0F -> full_o=1, count_o=16; 17th push 0xAA -> overrun_o=1 and count stays 16; drain yields 0x00..0x0F (0xAA absent); clr_ovr_i -> overrun_o=0.
- Full FIFO with push 0x55 and rd_en_i in the same cycle -> pop returns the oldest byte, count stays 16, overrun_o=0, and 0x55 is the last byte drained.
- Push 0x41 with rx_perr_i=1, then 0x42 with rx_ferr_i=1 -> first pop gives rd_perr_o=1, rd_ferr_o=0; second gives rd_perr_o=0, rd_ferr_o=1.
- Wrap-around: push 12, pop 12, push 10 (0xC0..0xC9) -> data drained in order across the pointer wrap; thresh_i=8 gives level_irq_o=1 while count_o>=8 and 0 after the count drops to 7.
- Edge cases with 5 entries stored:
  - flush_i together with rx_done_i -> count_o=0, empty_o=1, overrun_o=0, pushed byte discarded.
  - rx_en_i=0 with rx_done_i -> no push.
  - rd_en_i while empty -> rd_valid_o stays 0.
  - rst_i with 5 entries -> all outputs at their reset values on the next edge.
